// File: rtl/dcache_tag_ctrl.sv
// Tag SRAM controller for the data cache: invalidate sweep, lookup read port,
// round-robin fill/meta write arbitration and same-cycle write-to-lookup forwarding.
module dcache_tag_ctrl #(
    parameter int                    DATA_WIDTH = 24,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req,
    output logic                  init_busy,
    input  logic                  lk_valid,
    output logic                  lk_ready,
    input  logic [ADDR_WIDTH-1:0] lk_index,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_tag,
    input  logic                  fill_valid,
    output logic                  fill_ready,
    input  logic [ADDR_WIDTH-1:0] fill_index,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  meta_valid,
    output logic                  meta_ready,
    input  logic [ADDR_WIDTH-1:0] meta_index,
    input  logic [DATA_WIDTH-1:0] meta_data,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    typedef enum logic {SWEEP, READY} state_t;
    typedef enum logic {REQ_FILL, REQ_META} req_t;

    state_t                state_q, state_d;
    req_t                  rr_last_q, rr_last_d;
    logic [ADDR_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  fwd_hit_q, fwd_hit_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic                  disarm_q, disarm_d;
    logic [ADDR_WIDTH-1:0] last_idx_q, last_idx_d;

    logic                  grant_fill;
    logic                  grant_meta;
    logic [ADDR_WIDTH-1:0] wr_index;
    logic [DATA_WIDTH-1:0] wr_data;

    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        sweep_idx_d  = sweep_idx_q;
        resp_valid_d = 1'b0;
        fwd_hit_d    = 1'b0;
        fwd_data_d   = fwd_data_q;
        disarm_d     = disarm_q;
        last_idx_d   = last_idx_q;

        grant_fill = 1'b0;
        grant_meta = 1'b0;
        wr_index   = fill_index;
        wr_data    = fill_data;

        init_busy  = (state_q == SWEEP);
        lk_ready   = 1'b0;
        fill_ready = 1'b0;
        meta_ready = 1'b0;
        sram_csb0  = 1'b1;
        sram_web0  = 1'b1;
        sram_addr0 = last_idx_q;
        sram_din0  = INIT_VALUE;
        sram_csb1  = rst | ~lk_valid;
        sram_addr1 = lk_index;

        if (!rst) begin
            case (state_q)
                SWEEP: begin
                    sram_csb0   = 1'b0;
                    sram_web0   = 1'b0;
                    sram_addr0  = sweep_idx_q;
                    sram_din0   = INIT_VALUE;
                    sweep_idx_d = sweep_idx_q + 1'b1;
                    disarm_d    = 1'b1;
                    last_idx_d  = sweep_idx_q;
                    if (sweep_idx_q == '1) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    lk_ready   = 1'b1;
                    grant_fill = fill_valid & (~meta_valid | (rr_last_q == REQ_META));
                    grant_meta = meta_valid & (~fill_valid | (rr_last_q == REQ_FILL));
                    wr_index   = grant_meta ? meta_index : fill_index;
                    wr_data    = grant_meta ? meta_data : fill_data;
                    fill_ready = grant_fill;
                    meta_ready = grant_meta;

                    if (grant_fill || grant_meta) begin
                        sram_csb0  = 1'b0;
                        sram_web0  = 1'b0;
                        sram_addr0 = wr_index;
                        sram_din0  = wr_data;
                        rr_last_d  = grant_meta ? REQ_META : REQ_FILL;
                        disarm_d   = 1'b1;
                        last_idx_d = wr_index;
                    end else if (disarm_q) begin
                        // The SRAM keeps its latched write enable while deselected, so
                        // one selected read cycle clears it after any write activity.
                        sram_csb0 = 1'b0;
                        sram_web0 = 1'b1;
                        disarm_d  = 1'b0;
                    end

                    if (lk_valid) begin
                        resp_valid_d = 1'b1;
                        fwd_hit_d    = (grant_fill || grant_meta) && (wr_index == lk_index);
                        fwd_data_d   = wr_data;
                    end

                    if (flush_req) begin
                        state_d     = SWEEP;
                        sweep_idx_d = '0;
                    end
                end
                default: state_d = SWEEP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SWEEP;
            rr_last_q    <= REQ_META;
            sweep_idx_q  <= '0;
            resp_valid_q <= 1'b0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= '0;
            disarm_q     <= 1'b0;
            last_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            sweep_idx_q  <= sweep_idx_d;
            resp_valid_q <= resp_valid_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_data_q   <= fwd_data_d;
            disarm_q     <= disarm_d;
            last_idx_q   <= last_idx_d;
        end
    end

    // The SRAM does not bypass, so a same-cycle write to the looked-up index wins.
    assign resp_valid = resp_valid_q;
    assign resp_tag   = fwd_hit_q ? fwd_data_q : sram_dout1;

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Scoreboard bench for dcache_tag_ctrl: directed plan items plus random traffic,
// checked against an array-level model of the tag store and its sweep/arbitration rules.
module tb_dcache_tag_ctrl;

    localparam int          DW    = 24;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [23:0] INIT  = 24'h000000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_req = 1'b0;
    logic          init_busy;
    logic          lk_valid = 1'b0;
    logic          lk_ready;
    logic [AW-1:0] lk_index = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_tag;
    logic          fill_valid = 1'b0;
    logic          fill_ready;
    logic [AW-1:0] fill_index = '0;
    logic [DW-1:0] fill_data = '0;
    logic          meta_valid = 1'b0;
    logic          meta_ready;
    logic [AW-1:0] meta_index = '0;
    logic [DW-1:0] meta_data = '0;
    logic          sram_csb0;
    logic          sram_web0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic          sram_csb1;
    logic [AW-1:0] sram_addr1;
    logic [DW-1:0] sram_dout1;

    always #5 clk = ~clk;

    dcache_tag_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .INIT_VALUE(INIT)
    ) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .init_busy(init_busy),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_index(lk_index),
        .resp_valid(resp_valid), .resp_tag(resp_tag),
        .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_index(fill_index), .fill_data(fill_data),
        .meta_valid(meta_valid), .meta_ready(meta_ready),
        .meta_index(meta_index), .meta_data(meta_data),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    // SRAM environment: inputs latched at the edge, read data registered, no internal bypass.
    logic [DW-1:0] sram_mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] <= 24'($urandom);
    end

    always @(posedge clk) begin
        if (!sram_csb1) sram_dout1 <= sram_mem[sram_addr1];
        if (!sram_csb0 && !sram_web0) sram_mem[sram_addr0] <= sram_din0;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] tag;
        int            due;
    } exp_t;

    exp_t expq[$];

    // Reference model of the tag store and controller rules.
    logic [DW-1:0] ref_mem [DEPTH];
    int            busy_left   = 16;
    logic          prefer_fill = 1'b1;
    logic          disarm_due  = 1'b0;
    logic [AW-1:0] last_wr     = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every negedge, resp_valid must match the scoreboard head.
    initial begin
        exp_t e;
        logic exp_v;
        forever begin
            @(negedge clk);
            exp_v = (expq.size() > 0) && (expq[0].due == cyc);
            checkOutput("resp_valid", resp_valid, exp_v);
            if (exp_v) begin
                e = expq.pop_front();
                if (resp_valid === 1'b1) checkOutput("resp_tag", resp_tag, e.tag);
            end
        end
    end

    task automatic applyStimulus(input logic lkv, input logic [AW-1:0] lki,
                                 input logic fv, input logic [AW-1:0] fi, input logic [DW-1:0] fd,
                                 input logic mv, input logic [AW-1:0] mi, input logic [DW-1:0] md,
                                 input logic fl);
        logic          gf, gm;
        logic [AW-1:0] wi, si;
        logic [DW-1:0] wd;
        exp_t          e;
        lk_valid = lkv;   lk_index = lki;
        fill_valid = fv;  fill_index = fi;  fill_data = fd;
        meta_valid = mv;  meta_index = mi;  meta_data = md;
        flush_req = fl;
        @(negedge clk);
        checkOutput("csb1", sram_csb1, !lkv);
        if (lkv) checkOutput("addr1", sram_addr1, lki);
        if (busy_left > 0) begin
            si = 4'(DEPTH - busy_left);
            checkOutput("init_busy_sweep", init_busy, 1);
            checkOutput("lk_ready_sweep", lk_ready, 0);
            checkOutput("fill_ready_sweep", fill_ready, 0);
            checkOutput("meta_ready_sweep", meta_ready, 0);
            checkOutput("sweep_csb0", sram_csb0, 0);
            checkOutput("sweep_web0", sram_web0, 0);
            checkOutput("sweep_addr0", sram_addr0, si);
            checkOutput("sweep_din0", sram_din0, INIT);
            ref_mem[si] = INIT;
            busy_left--;
            disarm_due = 1'b1;
            last_wr = si;
        end else begin
            gf = fv && (!mv || prefer_fill);
            gm = mv && (!fv || !prefer_fill);
            wi = gf ? fi : mi;
            wd = gf ? fd : md;
            checkOutput("init_busy_ready", init_busy, 0);
            checkOutput("lk_ready", lk_ready, 1);
            checkOutput("fill_ready", fill_ready, gf);
            checkOutput("meta_ready", meta_ready, gm);
            if (gf || gm) begin
                checkOutput("wr_csb0", sram_csb0, 0);
                checkOutput("wr_web0", sram_web0, 0);
                checkOutput("wr_addr0", sram_addr0, wi);
                checkOutput("wr_din0", sram_din0, wd);
            end else if (disarm_due) begin
                checkOutput("disarm_csb0", sram_csb0, 0);
                checkOutput("disarm_web0", sram_web0, 1);
                checkOutput("disarm_addr0", sram_addr0, last_wr);
            end else begin
                checkOutput("idle_csb0", sram_csb0, 1);
            end
            if (lkv) begin
                e.tag = ((gf || gm) && wi == lki) ? wd : ref_mem[lki];
                e.due = cyc + 1;
                expq.push_back(e);
            end
            if (gf || gm) begin
                ref_mem[wi] = wd;
                last_wr = wi;
                disarm_due = 1'b1;
                prefer_fill = gm;
            end else begin
                disarm_due = 1'b0;
            end
            if (fl) busy_left = 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        lk_valid = 1'b1; fill_valid = 1'b1; meta_valid = 1'b1; flush_req = 1'b0;
        repeat (n) begin
            @(negedge clk);
            checkOutput("rst_init_busy", init_busy, 1);
            checkOutput("rst_lk_ready", lk_ready, 0);
            checkOutput("rst_fill_ready", fill_ready, 0);
            checkOutput("rst_meta_ready", meta_ready, 0);
            checkOutput("rst_csb0", sram_csb0, 1);
            checkOutput("rst_web0", sram_web0, 1);
            checkOutput("rst_csb1", sram_csb1, 1);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        lk_valid = 1'b0; fill_valid = 1'b0; meta_valid = 1'b0;
        busy_left = 16;
        prefer_fill = 1'b1;
        disarm_due = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(0, '0, 0, '0, '0, 0, '0, '0, 0);
    endtask

    task automatic doLookup(input logic [AW-1:0] idx);
        applyStimulus(1, idx, 0, '0, '0, 0, '0, '0, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
        @(posedge clk);
        #1;
        $display("[TB] reset sweep");
        doReset(2);
        repeat (16) idle();
        doLookup(4'd5);
        idle();

        $display("[TB] fill then lookup");
        applyStimulus(0, '0, 1, 4'd3, 24'hABC123, 0, '0, '0, 0);
        doLookup(4'd3);
        idle();

        $display("[TB] same-cycle forward");
        applyStimulus(1, 4'd7, 0, '0, '0, 1, 4'd7, 24'h800001, 0);
        idle();
        doLookup(4'd7);

        $display("[TB] contention");
        for (int i = 0; i < 4; i++)
            applyStimulus(0, '0, 1, 4'd1, 24'h111000 + 24'(i), 1, 4'd2, 24'h222000 + 24'(i), 0);
        doLookup(4'd1);
        doLookup(4'd2);
        idle();

        $display("[TB] flush with lookup and write in the same cycle");
        applyStimulus(0, '0, 1, 4'd5, 24'h5A5A5A, 0, '0, '0, 0);
        applyStimulus(1, 4'd5, 0, '0, '0, 1, 4'd5, 24'h0F0F0F, 1);
        repeat (16) idle();
        for (int i = 0; i < DEPTH; i++) doLookup(4'(i));
        idle();

        $display("[TB] reset mid-sweep");
        applyStimulus(0, '0, 1, 4'd9, 24'h999999, 0, '0, '0, 1);
        repeat (9) idle();
        doReset(1);
        repeat (16) idle();
        doLookup(4'd9);
        doLookup(4'd15);
        idle();

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom),
                          1'($urandom_range(0, 1)), 4'($urandom), 24'($urandom),
                          1'($urandom_range(0, 1)), 4'($urandom), 24'($urandom),
                          ($urandom_range(0, 59) == 0));
        end
        repeat (3) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
